// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, drives the instruction
// memory address, registers each fetched word with its PC, redirects through a
// loadable branch-target LUT and stops with `done` once the halt word is fetched.
module fetch_unit #(
    parameter int unsigned              PC_W      = 10,
    parameter int unsigned              INSTR_W   = 9,
    parameter int unsigned              LUT_AW    = 5,
    parameter logic [INSTR_W-1:0]       HALT_WORD = 9'b100100000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stall,
    input  logic                branch_en,
    input  logic [LUT_AW-1:0]   branch_idx,
    input  logic                lut_we,
    input  logic [LUT_AW-1:0]   lut_waddr,
    input  logic [PC_W-1:0]     lut_wdata,
    output logic [PC_W-1:0]     imem_addr,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic [INSTR_W-1:0]  instr,
    output logic [PC_W-1:0]     instr_pc,
    output logic                instr_valid,
    output logic                done
);

    localparam int unsigned LUT_N = 1 << LUT_AW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t               state_q, state_n;
    logic [PC_W-1:0]      pc_q, pc_n;
    logic [INSTR_W-1:0]   instr_q, instr_n;
    logic [PC_W-1:0]      ipc_q, ipc_n;
    logic                 valid_q, valid_n;
    logic                 done_q, done_n;
    logic [PC_W-1:0]      lut [LUT_N];
    logic [PC_W-1:0]      branch_target;

    // Branch target read is combinational; a write in the same cycle lands
    // only at the edge, so a colliding read sees the old entry.
    assign branch_target = lut[branch_idx];

    // Branch-target LUT: cleared by reset, written whenever lut_we is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < LUT_N; i++) begin
                lut[i] <= '0;
            end
        end else if (lut_we) begin
            lut[lut_waddr] <= lut_wdata;
        end
    end

    // State register plus PC and fetch pipeline register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            ipc_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
            instr_q <= instr_n;
            ipc_q   <= ipc_n;
            valid_q <= valid_n;
            done_q  <= done_n;
        end
    end

    // Next-state and next-register logic; branch beats stall beats fetch.
    always_comb begin
        state_n = state_q;
        pc_n    = pc_q;
        instr_n = instr_q;
        ipc_n   = ipc_q;
        valid_n = valid_q;
        done_n  = done_q;
        unique case (state_q)
            IDLE: begin
                pc_n    = '0;
                valid_n = 1'b0;
                if (start) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                if (branch_en) begin
                    pc_n    = branch_target;
                    valid_n = 1'b0;
                end else if (!stall) begin
                    instr_n = imem_rdata;
                    ipc_n   = pc_q;
                    valid_n = 1'b1;
                    if (imem_rdata == HALT_WORD) begin
                        state_n = HALT;
                    end else begin
                        pc_n = pc_q + PC_W'(1);
                    end
                end
            end
            HALT: begin
                valid_n = 1'b0;
                done_n  = 1'b1;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = ipc_q;
    assign instr_valid = valid_q;
    assign done        = done_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit (default widths plus a 4-bit PC
// instance for wraparound).
module tb_fetch_unit;

    localparam logic [8:0] HALT = 9'b100100000;

    logic        clk;
    logic        reset;
    logic        start, stall, branch_en, lut_we;
    logic [4:0]  branch_idx, lut_waddr;
    logic [9:0]  lut_wdata;
    logic [9:0]  imem_addr;
    logic [8:0]  imem_rdata;
    logic [8:0]  instr;
    logic [9:0]  instr_pc;
    logic        instr_valid, done;

    logic        w_start;
    logic [3:0]  w_addr;
    logic [8:0]  w_rdata;
    logic [8:0]  w_instr;
    logic [3:0]  w_instr_pc;
    logic        w_valid, w_done;

    logic [8:0]  imem [1024];

    int total;
    int bad;

    fetch_unit #(.PC_W(10), .INSTR_W(9), .LUT_AW(5), .HALT_WORD(HALT)) u_dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .branch_en(branch_en), .branch_idx(branch_idx),
        .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .done(done)
    );

    fetch_unit #(.PC_W(4), .INSTR_W(9), .LUT_AW(5), .HALT_WORD(HALT)) u_wrap (
        .clk(clk), .reset(reset), .start(w_start), .stall(1'b0),
        .branch_en(1'b0), .branch_idx(5'd0),
        .lut_we(1'b0), .lut_waddr(5'd0), .lut_wdata(4'd0),
        .imem_addr(w_addr), .imem_rdata(w_rdata),
        .instr(w_instr), .instr_pc(w_instr_pc), .instr_valid(w_valid), .done(w_done)
    );

    assign imem_rdata = imem[imem_addr];
    assign w_rdata    = {5'd0, w_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drop reset between edges and release it 1 ns after the next rising edge.
    task automatic async_reset();
        #3 reset = 1'b0;
        #1;
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pc", 32'(imem_addr), 32'd0);
        chk("rst_ipc", 32'(instr_pc), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic lut_load(input logic [4:0] idx, input logic [9:0] val);
        lut_we = 1'b1; lut_waddr = idx; lut_wdata = val;
        tick();
        lut_we = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0;
        reset = 1'b0; start = 1'b0; stall = 1'b0; branch_en = 1'b0;
        lut_we = 1'b0; branch_idx = '0; lut_waddr = '0; lut_wdata = '0;
        w_start = 1'b0;
        for (int i = 0; i < 1024; i++) imem[i] = 9'(i % 256);
        imem[9] = HALT;

        #2;
        chk("init_valid", 32'(instr_valid), 32'd0);
        chk("init_done", 32'(done), 32'd0);
        chk("init_pc", 32'(imem_addr), 32'd0);
        chk("init_instr", 32'(instr), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Straight-line run into the halt word.
        tick();
        chk("idle_valid", 32'(instr_valid), 32'd0);
        go();
        chk("start_nofetch", 32'(instr_valid), 32'd0);
        chk("start_pc", 32'(imem_addr), 32'd0);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("seq_instr", 32'(instr), 32'(i));
            chk("seq_ipc", 32'(instr_pc), 32'(i));
            chk("seq_valid", 32'(instr_valid), 32'd1);
            chk("seq_done", 32'(done), 32'd0);
        end
        tick();
        chk("halt_instr", 32'(instr), 32'(HALT));
        chk("halt_ipc", 32'(instr_pc), 32'd9);
        chk("halt_valid", 32'(instr_valid), 32'd1);
        chk("halt_done0", 32'(done), 32'd0);
        chk("halt_pc", 32'(imem_addr), 32'd9);
        start = 1'b1; branch_en = 1'b1; branch_idx = 5'd0;
        tick();
        chk("halt_done1", 32'(done), 32'd1);
        chk("halt_valid0", 32'(instr_valid), 32'd0);
        chk("halt_pc_hold", 32'(imem_addr), 32'd9);
        tick();
        chk("halt_done_held", 32'(done), 32'd1);
        chk("halt_pc_held", 32'(imem_addr), 32'd9);
        start = 1'b0; branch_en = 1'b0;
        imem[9] = 9'd9;

        // Reset out of HALT; done must drop without a clock edge.
        async_reset();

        // Branch via LUT[3]=20 from instr_pc 4.
        lut_load(5'd3, 10'd20);
        go();
        for (int i = 0; i < 5; i++) tick();
        chk("br_pre_ipc", 32'(instr_pc), 32'd4);
        branch_en = 1'b1; branch_idx = 5'd3;
        tick();
        branch_en = 1'b0;
        chk("br_bubble", 32'(instr_valid), 32'd0);
        chk("br_pc", 32'(imem_addr), 32'd20);
        tick();
        chk("br_tgt_ipc", 32'(instr_pc), 32'd20);
        chk("br_tgt_instr", 32'(instr), 32'd20);
        chk("br_tgt_valid", 32'(instr_valid), 32'd1);
        tick();
        chk("br_next_ipc", 32'(instr_pc), 32'd21);

        // Same-cycle write and read of LUT[3] returns the old entry.
        branch_en = 1'b1; branch_idx = 5'd3;
        lut_we = 1'b1; lut_waddr = 5'd3; lut_wdata = 10'd40;
        tick();
        branch_en = 1'b0; lut_we = 1'b0;
        chk("lut_old", 32'(imem_addr), 32'd20);
        tick();
        chk("lut_old_ipc", 32'(instr_pc), 32'd20);
        branch_en = 1'b1;
        tick();
        branch_en = 1'b0;
        chk("lut_new", 32'(imem_addr), 32'd40);

        // Stall freeze, then branch during stall.
        async_reset();
        lut_load(5'd7, 10'd100);
        go();
        for (int i = 0; i < 3; i++) tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_ipc", 32'(instr_pc), 32'd2);
            chk("stall_instr", 32'(instr), 32'd2);
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_pc", 32'(imem_addr), 32'd3);
        end
        branch_en = 1'b1; branch_idx = 5'd7;
        tick();
        branch_en = 1'b0; stall = 1'b0;
        chk("stbr_valid", 32'(instr_valid), 32'd0);
        chk("stbr_pc", 32'(imem_addr), 32'd100);
        tick();
        chk("stbr_ipc", 32'(instr_pc), 32'd100);
        chk("stbr_instr", 32'(instr), 32'd100);

        // Halt word flushed by a branch is never acted on.
        async_reset();
        imem[6] = HALT;
        lut_load(5'd1, 10'd50);
        go();
        for (int i = 0; i < 6; i++) tick();
        chk("fl_pre_ipc", 32'(instr_pc), 32'd5);
        branch_en = 1'b1; branch_idx = 5'd1;
        tick();
        branch_en = 1'b0;
        chk("fl_valid", 32'(instr_valid), 32'd0);
        chk("fl_pc", 32'(imem_addr), 32'd50);
        tick();
        chk("fl_ipc", 32'(instr_pc), 32'd50);
        chk("fl_done", 32'(done), 32'd0);
        tick();
        chk("fl_done2", 32'(done), 32'd0);
        chk("fl_ipc2", 32'(instr_pc), 32'd51);
        imem[6] = 9'd6;

        // Mid-run reset: needs start again, LUT cleared.
        async_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rr_idle_valid", 32'(instr_valid), 32'd0);
            chk("rr_idle_pc", 32'(imem_addr), 32'd0);
        end
        go();
        tick();
        tick();
        chk("rr_ipc", 32'(instr_pc), 32'd1);
        branch_en = 1'b1; branch_idx = 5'd1;
        tick();
        branch_en = 1'b0;
        chk("rr_lut_zero", 32'(imem_addr), 32'd0);
        chk("rr_lut_valid", 32'(instr_valid), 32'd0);

        // 4-bit PC wraps 15 -> 0.
        w_start = 1'b1;
        tick();
        w_start = 1'b0;
        for (int k = 0; k < 18; k++) begin
            tick();
            chk("wrap_ipc", 32'(w_instr_pc), 32'(k % 16));
            chk("wrap_instr", 32'(w_instr), 32'(k % 16));
        end
        chk("wrap_valid", 32'(w_valid), 32'd1);
        chk("wrap_done", 32'(w_done), 32'd0);
        chk("wrap_pc", 32'(w_addr), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage for the 9-bit-instruction processor. It owns the program counter, drives the instruction-memory address, registers each fetched 9-bit word with its PC for the downstream decode/execute datapath, redirects on taken branches through a loadable branch-target lookup table, and raises `done` when the halt word is fetched. It sits directly upstream of decode, between the instruction memory and the datapath in `top_level`.

## Interface
Parameters:
- `PC_W`, 10, PC / instruction-memory address width
- `INSTR_W`, 9, instruction width
- `LUT_AW`, 5, branch-target LUT index width (2^LUT_AW entries of PC_W bits)
- `HALT_WORD`, 9'b100100000, instruction encoding that terminates the program

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low; asserted (0) clears all state immediately
- `start`  in  1  leave IDLE and begin fetching at PC 0
- `stall`  in  1  hold PC and registered instruction
- `branch_en`  in  1  taken branch for the instruction currently in `instr`
- `branch_idx`  in  LUT_AW  LUT entry holding the branch target
- `lut_we`  in  1  write enable for the branch-target LUT
- `lut_waddr`  in  LUT_AW  LUT write index
- `lut_wdata`  in  PC_W  LUT write data
- `imem_addr`  out  PC_W  instruction-memory address (= current PC)
- `imem_rdata`  in  INSTR_W  instruction-memory combinational read data
- `instr`  out  INSTR_W  registered instruction to decode
- `instr_pc`  out  PC_W  PC of `instr`
- `instr_valid`  out  1  `instr` is live
- `done`  out  1  program halted; held until reset

## Operation
- States: IDLE, RUN, HALT. Reset → IDLE.
- Reset values: PC 0, `instr` 0, `instr_pc` 0, `instr_valid` 0, `done` 0, all LUT entries 0.
- `imem_addr` = PC at all times (combinational from PC register).
- IDLE: PC held at 0, `instr_valid` 0. `start`=1 → RUN next cycle; no fetch is registered in the `start` cycle.
- RUN, per cycle, priority highest first:
  - `branch_en`: PC ← LUT[`branch_idx`]; `instr_valid` ← 0 (the word at the old PC is discarded, never decoded, never halt-checked). Overrides `stall`.
  - `stall`: PC, `instr`, `instr_pc`, `instr_valid` all hold.
  - otherwise: `instr` ← `imem_rdata`, `instr_pc` ← PC, `instr_valid` ← 1, PC ← PC+1 modulo 2^PC_W (PC 2^PC_W−1 wraps to 0).
    - If `imem_rdata` == HALT_WORD: state ← HALT, PC not incremented (held at halt address).
- HALT: PC frozen; `instr_valid` ← 0 one cycle after entry; `done` ← 1 one cycle after entry and held. `start`, `stall`, `branch_en` ignored. Only reset exits.
- LUT: synchronous write when `lut_we`, in any state. Read is combinational; same-cycle write and branch read of the same index uses the old entry.
- `start` in RUN or HALT ignored.

## Timing
- Fetch latency: word at `imem_addr` in cycle N appears on `instr` with `instr_valid`=1 in cycle N+1.
- Sequential throughput: one instruction per cycle with `stall`=0.
- Branch penalty: one bubble cycle (`instr_valid`=0) then target word.
- Halt: halt word on `instr` (valid) at cycle H; `done`=1 and `instr_valid`=0 from H+1.
- `reset` falling edge clears outputs without waiting for `clk`; release is sampled on the next rising edge, first action is IDLE.
- Reset mid-RUN or in HALT: all state and LUT cleared, `done` drops immediately.

## Test plan
- Straight-line: imem[0..8] = 9'h000..9'h008, imem[9] = HALT_WORD, pulse `start` → `instr` 0..8 on 9 consecutive cycles with `instr_pc` 0..8, then halt word at `instr_pc` 9, `done`=1 next cycle, PC stays 9.
- Branch: LUT[3]=20 loaded in IDLE, `branch_en`=1 with `branch_idx`=3 while `instr_pc`=4 → one cycle `instr_valid`=0, then `instr_pc`=20; word at PC 5 never valid.
- Stall/branch collision: `stall`=1 for 3 cycles at `instr_pc`=2 → outputs frozen; assert `branch_en` during stall → redirect taken, stall ignored.
- Flushed halt: HALT_WORD at PC 6, branch from `instr_pc`=5 → no halt, `done` stays 0.
- Wrap: PC_W=4, no halt word, run 18 cycles → `instr_pc` goes 15 → 0.
- Async reset: drop `reset` mid-RUN between edges → `instr_valid`, `done`, PC 0 immediately; LUT reads 0; `start` required to resume.
